// File: rtl/imem_prefetch.sv
// imem_prefetch: sequential instruction prefetcher feeding a DEPTH-entry FIFO, flushed on redirect.
// Define IMEM_PREFETCH_BYPASS_EN to forward an acked word straight to the core when the FIFO is empty.
module imem_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
    state_t        state_q, state_d;
    logic [31:0]   fa_q, fa_d, addr_q, addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem [DEPTH];
    logic          fifo_valid, accept, bypass, push, pop;
    always_comb begin
        fifo_valid  = count_q != '0;
        accept      = state_q == REQ && mem_ack && !redirect;
`ifdef IMEM_PREFETCH_BYPASS_EN
        bypass      = accept && !fifo_valid;
`else
        bypass      = 1'b0;
`endif
        push        = accept && !(bypass && instr_ready);
        pop         = fifo_valid && instr_ready && !redirect;
        instr_valid = fifo_valid || bypass;
        instr       = fifo_valid ? data_mem[rd_q] : (bypass ? mem_rdata : '0);
        instr_pc    = fifo_valid ? pc_mem[rd_q] : (bypass ? addr_q : '0);
        mem_req     = state_q != IDLE;
        mem_addr    = addr_q;
        wr_d        = push ? wr_q + AW'(1) : wr_q;
        rd_d        = pop ? rd_q + AW'(1) : rd_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        fa_d        = accept ? fa_q + 32'd4 : fa_q;
        if (redirect) begin
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
            fa_d    = {redirect_addr[31:2], 2'b00};
        end
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (!redirect && count_q < FULL) ? REQ : IDLE;
            REQ:     state_d = redirect ? (mem_ack ? IDLE : DISCARD)
                                        : (mem_ack ? ((count_d < FULL) ? REQ : IDLE) : REQ);
            DISCARD: state_d = mem_ack ? IDLE : DISCARD;
            default: state_d = IDLE;
        endcase
        // The issued address is frozen for the life of a request, even across a redirect.
        addr_d = state_d == REQ ? fa_d : addr_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            fa_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            fa_q    <= fa_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_q] <= mem_rdata;
            pc_mem[wr_q]   <= addr_q;
        end
    end
endmodule

// File: tb/tb_imem_prefetch.sv
// tb_imem_prefetch: directed checks of fetch sequencing, full FIFO, redirects, PC wrap and reset abort.
module tb_imem_prefetch;
    logic        clk = 1'b0, reset = 1'b0, redirect = 1'b0, mem_ack = 1'b0, instr_ready = 1'b0, ack2 = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        mem_req, instr_valid, req2, valid2;
    logic [31:0] mem_addr, mem_rdata, instr, instr_pc, addr2, rdata2, instr2, pc2;
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] exp_ins [4] = '{32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008, 32'hC0DE_000C};
    int n_chk = 0, n_pass = 0;
    always #5 clk = ~clk;
    assign mem_rdata = {16'hC0DE, mem_addr[15:0]};
    assign rdata2    = {16'hBEEF, addr2[15:0]};
    imem_prefetch dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );
    imem_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .reset(reset), .redirect(1'b0), .redirect_addr(32'h0),
        .mem_req(req2), .mem_addr(addr2), .mem_ack(ack2), .mem_rdata(rdata2),
        .instr_valid(valid2), .instr_ready(1'b1), .instr(instr2), .instr_pc(pc2)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic do_reset;
        redirect    = 1'b0;
        mem_ack     = 1'b0;
        ack2        = 1'b0;
        instr_ready = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask
    initial begin
        #1 reset = 1'b1;
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_req2", req2, 0);
        @(negedge clk);
        reset = 1'b0;
        step;
        chk("first_req", mem_req, 1);
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("seq_addr", mem_addr, exp_pc[i]);
            mem_ack = 1'b0; step;
            mem_ack = 1'b1; step;
            mem_ack = 1'b0;
            chk("seq_valid", instr_valid, 1);
            chk("seq_pc", instr_pc, exp_pc[i]);
            chk("seq_instr", instr, exp_ins[i]);
        end
        do_reset; step;
        mem_ack = 1'b1; repeat (4) step; mem_ack = 1'b0;
        chk("full_req", mem_req, 0);
        chk("full_head_pc", instr_pc, 0);
        chk("full_head", instr, 32'hC0DE_0000);
        repeat (2) step;
        chk("full_hold", mem_req, 0);
        instr_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step;
            chk("drain_pc", instr_pc, exp_pc[i]);
        end
        step;
        chk("drain_empty", instr_valid, 0);
        chk("drain_addr", mem_addr, 32'h10);
        do_reset; instr_ready = 1'b1; step;
        mem_ack = 1'b1; repeat (2) step; mem_ack = 1'b0;
        chk("rd_pend_addr", mem_addr, 32'h8);
        redirect = 1'b1; redirect_addr = 32'h0000_0103; step; redirect = 1'b0;
        chk("rd_flush", instr_valid, 0);
        chk("rd_hold_req", mem_req, 1);
        chk("rd_hold_addr", mem_addr, 32'h8);
        mem_ack = 1'b1; step; mem_ack = 1'b0;
        chk("rd_drop", instr_valid, 0);
        chk("rd_idle", mem_req, 0);
        step;
        chk("rd_new_req", mem_req, 1);
        chk("rd_new_addr", mem_addr, 32'h100);
        mem_ack = 1'b1; step; mem_ack = 1'b0;
        chk("rd_new_valid", instr_valid, 1);
        chk("rd_new_pc", instr_pc, 32'h100);
        chk("rd_new_instr", instr, 32'hC0DE_0100);
        do_reset; step;
        mem_ack = 1'b1; redirect = 1'b1; redirect_addr = 32'h40; step;
        mem_ack = 1'b0; redirect = 1'b0;
        chk("same_nopush", instr_valid, 0);
        chk("same_idle", mem_req, 0);
        step;
        chk("same_req", mem_req, 1);
        chk("same_addr", mem_addr, 32'h40);
        redirect = 1'b1; redirect_addr = 32'h80; step;
        redirect_addr = 32'h204; step; redirect = 1'b0;
        chk("disc_req", mem_req, 1);
        chk("disc_addr", mem_addr, 32'h40);
        mem_ack = 1'b1; step; mem_ack = 1'b0;
        chk("disc_drop", instr_valid, 0);
        step;
        chk("disc_new_addr", mem_addr, 32'h204);
        do_reset; step;
        mem_ack = 1'b1; step; mem_ack = 1'b0;
        chk("rr_pre_addr", mem_addr, 32'h4);
        reset = 1'b1;
        #1;
        chk("rr_req", mem_req, 0);
        chk("rr_valid", instr_valid, 0);
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1; step; mem_ack = 1'b0;
        chk("rr_ignored", instr_valid, 0);
        chk("rr_req_again", mem_req, 1);
        chk("rr_addr", mem_addr, 32'h0);
        do_reset; step;
        chk("w_addr0", addr2, 32'hFFFF_FFF8);
        ack2 = 1'b1; step;
        chk("w_addr1", addr2, 32'hFFFF_FFFC);
        step; ack2 = 1'b0;
        chk("w_addr2", addr2, 32'h0);
        chk("w_valid", valid2, 1);
        chk("w_pc", pc2, 32'hFFFF_FFFC);
        chk("w_instr", instr2, 32'hBEEF_FFFC);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/imem_prefetch.md
IMEM_PREFETCH -- requirements
Module: imem_prefetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 The block SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port redirect  input  1  branch taken (PCSrc), flush and refetch.
REQ-006 The block SHALL have port redirect_addr  input  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-007 The block SHALL have port mem_req  output  1  instruction-memory read request.
REQ-008 The block SHALL have port mem_addr  output  32  word-aligned read address.
REQ-009 The block SHALL have port mem_ack  input  1  read data valid this cycle.
REQ-010 The block SHALL have port mem_rdata  input  32  read data.
REQ-011 The block SHALL have port instr_valid  output  1  instr/instr_pc hold a valid entry.
REQ-012 The block SHALL have port instr_ready  input  1  core consumes head entry this cycle.
REQ-013 The block SHALL have port instr  output  32  instruction word at FIFO head.
REQ-014 The block SHALL have port instr_pc  output  32  address of instr.

Function
REQ-015 Fetch address register fa SHALL advance by 4 on each accepted (non-discarded) ack; wrap 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-016 FSM SHALL have states IDLE, REQ, DISCARD.
REQ-017 IDLE -> REQ when count + 0 < DEPTH and no redirect; mem_req=1, mem_addr=fa, from the cycle of entry into REQ.
REQ-018 In REQ, mem_req and mem_addr SHALL stay stable until the mem_ack cycle; at most one request outstanding.
REQ-019 REQ with mem_ack and no redirect: push {mem_rdata, mem_addr}, fa += 4; next state REQ if count after push < DEPTH, else IDLE.
REQ-020 Redirect in any state: FIFO count -> 0, fa -> {redirect_addr[31:2],2'b00}; redirect has priority over push and pop.
REQ-021 Redirect in REQ without same-cycle mem_ack: -> DISCARD; mem_req stays 1 with old mem_addr until ack; acked data dropped, then -> IDLE.
REQ-022 Redirect in REQ with same-cycle mem_ack: data dropped, -> IDLE.
REQ-023 Redirect in DISCARD: fa updated again, FIFO stays empty, state remains DISCARD until ack.
REQ-024 Pop SHALL occur when instr_valid && instr_ready && !redirect; simultaneous push and pop leaves count unchanged.
REQ-025 Full (count == DEPTH): no new request issued; in-flight ack cannot occur since issue requires free slot.
REQ-026 Empty: instr_valid=0; instr_ready ignored.
REQ-027 Latency: ack in cycle N -> instr_valid in cycle N+1 (without bypass), FIFO order preserved.

Reset
REQ-028 Reset SHALL force state IDLE, count 0, fa RESET_PC, mem_req 0, instr_valid 0; instr/instr_pc 0.
REQ-029 Reset mid-request SHALL abandon the transaction; an ack arriving after reset release while IDLE SHALL be ignored.

Configuration
REQ-030 Macro IMEM_PREFETCH_BYPASS_EN, when defined, SHALL forward mem_rdata/mem_addr to instr/instr_pc with instr_valid=1 in the ack cycle when FIFO empty, state REQ, no redirect; if instr_ready that cycle, the word SHALL NOT be pushed.
REQ-031 Without IMEM_PREFETCH_BYPASS_EN, instr_valid SHALL depend only on registered FIFO state (REQ-027).

Verification
REQ-032 Reset, mem_ack 1 cycle after each req, instr_ready=1 -> instr_pc sequence 0,4,8,12; instr = mem_rdata per address.
REQ-033 instr_ready=0, DEPTH=4 -> exactly 4 acks accepted, mem_req low after 4th, instr_pc head 0.
REQ-034 redirect=1, redirect_addr=32'h0000_0103 while req to 8 pending -> ack data for 8 dropped, next mem_addr 32'h0000_0100, first instr_pc 0x100.
REQ-035 redirect and mem_ack same cycle -> no push, next request to redirect address 2 cycles later at most.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 Assert reset with req outstanding, release, ack -> instr_valid stays 0, next req to RESET_PC.
